// File: rtl/seg7_capture_if.sv
// Display-bus capture interface: scanner-side inputs plus the decoded frame outputs.
interface seg7_capture_if;
  logic [7:0]  digitselect;
  logic [7:0]  segments;
  logic [31:0] value;
  logic [7:0]  dp;
  logic [7:0]  digit_err;
  logic        err;
  logic        frame_valid;

  modport master (
    output digitselect,
    output segments,
    input  value,
    input  dp,
    input  digit_err,
    input  err,
    input  frame_valid
  );

  modport slave (
    input  digitselect,
    input  segments,
    output value,
    output dp,
    output digit_err,
    output err,
    output frame_valid
  );
endinterface

// File: rtl/seg7_capture.sv
// Seven-segment bus capture: synchronizes the active-low select/segment pair, waits for a
// stable single digit select, decodes the glyph and publishes a full 8-digit frame.
module seg7_capture #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SETTLE      = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  seg7_capture_if.slave  bus
);

  localparam logic [7:0] SettleCnt = 8'(SETTLE);

  typedef enum logic [1:0] {StIdle, StSettle, StHeld} state_e;

  logic [7:0]  r_sel_sync [SYNC_STAGES];
  logic [7:0]  r_seg_sync [SYNC_STAGES];

  state_e      r_state;
  logic [7:0]  r_cnt;
  logic [7:0]  r_cur_sel;

  logic [31:0] r_work_val;
  logic [7:0]  r_work_dp;
  logic [7:0]  r_work_err;
  logic [7:0]  r_seen;

  logic [31:0] r_value;
  logic [7:0]  r_dp;
  logic [7:0]  r_digit_err;
  logic        r_err;
  logic        r_frame_valid;

  logic [7:0]  w_sel_s;
  logic [7:0]  w_seg_s;
  logic [7:0]  w_sel_n;
  logic [6:0]  w_glyph;
  logic [3:0]  w_nib;
  logic        w_derr;
  logic        w_dp;
  logic        w_single;
  logic        w_same;
  logic        w_load;
  logic        w_cap;
  logic [7:0]  w_cnt_inc;
  logic [7:0]  w_seen_d;

  // Synchronizers idle at all-ones, i.e. nothing selected and all segments dark.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sel_sync[i] <= 8'hFF;
        r_seg_sync[i] <= 8'hFF;
      end
    end else begin
      r_sel_sync[0] <= bus.digitselect;
      r_seg_sync[0] <= bus.segments;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sel_sync[i] <= r_sel_sync[i-1];
        r_seg_sync[i] <= r_seg_sync[i-1];
      end
    end
  end

  assign w_sel_s = r_sel_sync[SYNC_STAGES-1];
  assign w_seg_s = r_seg_sync[SYNC_STAGES-1];
  assign w_sel_n = ~w_sel_s;
  assign w_glyph = ~w_seg_s[7:1];
  assign w_dp    = ~w_seg_s[0];

  always_comb begin
    w_nib  = 4'h0;
    w_derr = 1'b0;
    unique case (w_glyph)
      7'b1111110: w_nib = 4'h0;
      7'b0110000: w_nib = 4'h1;
      7'b1101101: w_nib = 4'h2;
      7'b1111001: w_nib = 4'h3;
      7'b0110011: w_nib = 4'h4;
      7'b1011011: w_nib = 4'h5;
      7'b1011111: w_nib = 4'h6;
      7'b1110000: w_nib = 4'h7;
      7'b1111111: w_nib = 4'h8;
      7'b1111011: w_nib = 4'h9;
      7'b1110111: w_nib = 4'hA;
      7'b0011111: w_nib = 4'hB;
      7'b1001110: w_nib = 4'hC;
      7'b0111101: w_nib = 4'hD;
      7'b1001111: w_nib = 4'hE;
      7'b1000111: w_nib = 4'hF;
      default:    w_derr = 1'b1;
    endcase
  end

  // A new single-low select (from IDLE, or differing from cur_sel) restarts the count at 1.
  always_comb begin
    w_single  = (w_sel_n != 8'h00) && ((w_sel_n & (w_sel_n - 8'd1)) == 8'h00);
    w_same    = (w_sel_s == r_cur_sel);
    w_load    = w_single && ((r_state == StIdle) || !w_same);
    w_cnt_inc = r_cnt + 8'd1;
    if (w_load) begin
      w_cap = (SettleCnt == 8'd1);
    end else begin
      w_cap = (r_state == StSettle) && w_same && (w_cnt_inc == SettleCnt);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_cnt     <= 8'd0;
      r_cur_sel <= 8'hFF;
    end else if (!w_single) begin
      r_state <= StIdle;
      r_cnt   <= 8'd0;
    end else if (w_load) begin
      r_cur_sel <= w_sel_s;
      r_cnt     <= 8'd1;
      r_state   <= w_cap ? StHeld : StSettle;
    end else if (r_state == StSettle) begin
      r_cnt   <= w_cnt_inc;
      r_state <= w_cap ? StHeld : StSettle;
    end
  end

  // A capture on the publishing edge seeds the next frame rather than being cleared.
  always_comb begin
    w_seen_d = (r_seen == 8'hFF) ? 8'h00 : r_seen;
    if (w_cap) begin
      w_seen_d = w_seen_d | w_sel_n;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_work_val    <= 32'h0;
      r_work_dp     <= 8'h00;
      r_work_err    <= 8'h00;
      r_seen        <= 8'h00;
      r_value       <= 32'h0;
      r_dp          <= 8'h00;
      r_digit_err   <= 8'h00;
      r_err         <= 1'b0;
      r_frame_valid <= 1'b0;
    end else begin
      r_seen        <= w_seen_d;
      r_frame_valid <= 1'b0;
      if (r_seen == 8'hFF) begin
        r_value       <= r_work_val;
        r_dp          <= r_work_dp;
        r_digit_err   <= r_work_err;
        r_err         <= |r_work_err;
        r_frame_valid <= 1'b1;
      end
      if (w_cap) begin
        for (int i = 0; i < 8; i++) begin
          if (w_sel_n[i]) begin
            r_work_val[4*i +: 4] <= w_nib;
            r_work_dp[i]         <= w_dp;
            r_work_err[i]        <= w_derr;
          end
        end
      end
    end
  end

  assign bus.value       = r_value;
  assign bus.dp          = r_dp;
  assign bus.digit_err   = r_digit_err;
  assign bus.err         = r_err;
  assign bus.frame_valid = r_frame_valid;

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture: scans the display bus and checks the published frames.
module tb_seg7_capture;

  logic clk;
  logic reset_n;
  int   n_assert;
  int   n_fail;
  int   fv_cnt;

  seg7_capture_if bus_if ();

  seg7_capture #(
    .SYNC_STAGES(2),
    .SETTLE     (4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts cycles with frame_valid high, so a stretched pulse shows up as an extra frame.
  initial fv_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (bus_if.frame_valid === 1'b1) fv_cnt++;
  end

  function automatic logic [7:0] seg_of(input logic [3:0] h, input logic dp_on);
    logic [6:0] g;
    case (h)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1111011;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;
      4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;
      default: g = 7'b1000111;
    endcase
    return {~g, ~dp_on};
  endfunction

  function automatic logic [7:0] sel_of(input int d);
    logic [7:0] one;
    one = 8'h01 << d;
    return ~one;
  endfunction

  task automatic drive(input logic [7:0] sel, input logic [7:0] sg, input int n);
    bus_if.digitselect = sel;
    bus_if.segments    = sg;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [31:0] vals, input logic [7:0] dpm, input logic [7:0] blank);
    for (int i = 0; i < 8; i++) begin
      drive(sel_of(i), blank[i] ? 8'hFF : seg_of(vals[4*i +: 4], dpm[i]), 10);
    end
    drive(8'hFF, 8'hFF, 5);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    bus_if.digitselect = 8'hFF;
    bus_if.segments    = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_value", bus_if.value, 32'h0);
    check("rst_dp", {24'h0, bus_if.dp}, 32'h0);
    check("rst_digit_err", {24'h0, bus_if.digit_err}, 32'h0);
    check("rst_err", {31'h0, bus_if.err}, 32'h0);
    check("rst_frame_valid", {31'h0, bus_if.frame_valid}, 32'h0);
    reset_n = 1'b1;
    drive(8'hFF, 8'hFF, 3);

    // Basic scan, digit i shows 8-i.
    scan(32'h12345678, 8'h00, 8'h00);
    check("scan1_frames", fv_cnt, 32'd1);
    check("scan1_value", bus_if.value, 32'h12345678);
    check("scan1_err", {31'h0, bus_if.err}, 32'h0);
    check("scan1_dp", {24'h0, bus_if.dp}, 32'h0);
    check("scan1_digit_err", {24'h0, bus_if.digit_err}, 32'h0);

    // Decimal points on digits 0 and 7.
    scan(32'h12345678, 8'h81, 8'h00);
    check("dp_frames", fv_cnt, 32'd2);
    check("dp_dp", {24'h0, bus_if.dp}, 32'h81);
    check("dp_value", bus_if.value, 32'h12345678);

    // Digit 3 blank.
    scan(32'h12345678, 8'h00, 8'h08);
    check("blank_frames", fv_cnt, 32'd3);
    check("blank_value", bus_if.value, 32'h12340678);
    check("blank_digit_err", {24'h0, bus_if.digit_err}, 32'h08);
    check("blank_err", {31'h0, bus_if.err}, 32'h1);

    // Short glitches on digit 7 between legal dwells, then a two-low select.
    for (int i = 0; i < 7; i++) begin
      drive(sel_of(i), seg_of(4'(8 - i), 1'b0), 10);
      drive(sel_of(7), seg_of(4'hE, 1'b0), 3);
    end
    drive(8'hFC, seg_of(4'h0, 1'b0), 10);
    check("glitch_no_early_frame", fv_cnt, 32'd3);
    check("glitch_value_held", bus_if.value, 32'h12340678);
    drive(sel_of(7), seg_of(4'h1, 1'b0), 10);
    drive(8'hFF, 8'hFF, 5);
    check("glitch_frames", fv_cnt, 32'd4);
    check("glitch_value", bus_if.value, 32'h12345678);
    check("glitch_err", {31'h0, bus_if.err}, 32'h0);

    // Digit 2 captured as A, then again as F within the same frame.
    drive(sel_of(0), seg_of(4'h8, 1'b0), 10);
    drive(sel_of(1), seg_of(4'h7, 1'b0), 10);
    drive(sel_of(2), seg_of(4'hA, 1'b0), 10);
    drive(sel_of(3), seg_of(4'h5, 1'b0), 10);
    drive(sel_of(2), seg_of(4'hF, 1'b0), 10);
    for (int i = 4; i < 8; i++) drive(sel_of(i), seg_of(4'(8 - i), 1'b0), 10);
    drive(8'hFF, 8'hFF, 5);
    check("recap_frames", fv_cnt, 32'd5);
    check("recap_value", bus_if.value, 32'h12345F78);

    // Reset after five captures; outputs clear immediately, then a fresh frame.
    for (int i = 0; i < 5; i++) drive(sel_of(i), seg_of(4'(i + 1), 1'b0), 10);
    #2;
    reset_n = 1'b0;
    bus_if.digitselect = 8'hFF;
    bus_if.segments    = 8'hFF;
    #1;
    check("midrst_value", bus_if.value, 32'h0);
    check("midrst_dp", {24'h0, bus_if.dp}, 32'h0);
    check("midrst_digit_err", {24'h0, bus_if.digit_err}, 32'h0);
    check("midrst_err", {31'h0, bus_if.err}, 32'h0);
    check("midrst_frame_valid", {31'h0, bus_if.frame_valid}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive(8'hFF, 8'hFF, 3);
    // Descending order: stale seen bits for digits 0..4 would publish early.
    for (int i = 7; i >= 1; i--) drive(sel_of(i), seg_of(4'(i + 1), 1'b0), 10);
    check("postrst_no_early_frame", fv_cnt, 32'd5);
    check("postrst_value_zero", bus_if.value, 32'h0);
    drive(sel_of(0), seg_of(4'h1, 1'b0), 10);
    drive(8'hFF, 8'hFF, 5);
    check("postrst_frames", fv_cnt, 32'd6);
    check("postrst_value", bus_if.value, 32'h87654321);
    check("postrst_err", {31'h0, bus_if.err}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
